// File: rtl/m2_sched_pkg.sv
// Shared types and constants for the milestone-2 IDCT block scheduler.
package m2_sched_pkg;

   typedef enum logic [2:0] {
      S_M2_IDLE,
      S_M2_LEAD_FS,
      S_M2_LEAD_CT,
      S_M2_CS_FS,
      S_M2_CT_WS,
      S_M2_LO_CS,
      S_M2_LO_WS,
      S_M2_DONE
   } m2_sched_state_type;

   localparam int Y_BLOCKS       = 1200;
   localparam int UV_BLOCKS      = 600;
   localparam int NUM_BLOCKS_DEF = Y_BLOCKS + 2 * UV_BLOCKS;

endpackage

// File: rtl/m2_done_latch.sv
// Sticky capture of one engine's done; ignores done while guard is high, clear wins over set.
module m2_done_latch (
   input  logic CLOCK_50_I,
   input  logic Resetn,
   input  logic clear,
   input  logic guard,
   input  logic done,
   output logic flag
);

   always_ff @(posedge CLOCK_50_I) begin
      if (!Resetn)
         flag <= 1'b0;
      else if (clear)
         flag <= 1'b0;
      else if (done && !guard)
         flag <= 1'b1;
   end

endmodule

// File: rtl/m2_block_scheduler.sv
// Two-stage overlapped FS/CT/CS/WS sequencer for all IDCT blocks, owning the SRAM port.
// Optional stall counter built only when M2_SCHED_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for m2_start
// LEAD_FS | fetch block 0
// LEAD_CT | compute T of block 0
// CS_FS   | compute S of block n, fetch block n+1
// CT_WS   | compute T of block n+1, write S of block n
// LO_CS   | compute S of last block
// LO_WS   | write S of last block
// DONE    | one-cycle m2_done
module m2_block_scheduler
   import m2_sched_pkg::*;
#(
   parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
   input  logic        CLOCK_50_I,
   input  logic        Resetn,
   input  logic        m2_start,
   output logic        m2_done,
   output logic        fs_start,
   output logic        ct_start,
   output logic        cs_start,
   output logic        ws_start,
   input  logic        fs_done,
   input  logic        ct_done,
   input  logic        cs_done,
   input  logic        ws_done,
   input  logic [17:0] fs_sram_address,
   input  logic [17:0] ws_sram_address,
   input  logic [15:0] ws_sram_write_data,
   input  logic        ws_sram_we_n,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic [11:0] block_count,
   output logic [31:0] perf_stall_cycles
);

   m2_sched_state_type state;
   logic entry;
   logic fs_act, ct_act, cs_act, ws_act;
   logic fs_flag, ct_flag, cs_flag, ws_flag;
   logic all_set, leave, fs_rise;

   assign fs_act = (state == S_M2_LEAD_FS) || (state == S_M2_CS_FS);
   assign ct_act = (state == S_M2_LEAD_CT) || (state == S_M2_CT_WS);
   assign cs_act = (state == S_M2_CS_FS)   || (state == S_M2_LO_CS);
   assign ws_act = (state == S_M2_CT_WS)   || (state == S_M2_LO_WS);

   assign all_set = (!fs_act || fs_flag) && (!ct_act || ct_flag) &&
                    (!cs_act || cs_flag) && (!ws_act || ws_flag);
   assign leave   = (fs_act || ct_act || cs_act || ws_act) && all_set;
   assign fs_rise = fs_act && fs_done && !entry && !fs_flag;

   m2_done_latch u_fs_latch (.CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .clear(leave),
                             .guard(entry), .done(fs_done && fs_act), .flag(fs_flag));
   m2_done_latch u_ct_latch (.CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .clear(leave),
                             .guard(entry), .done(ct_done && ct_act), .flag(ct_flag));
   m2_done_latch u_cs_latch (.CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .clear(leave),
                             .guard(entry), .done(cs_done && cs_act), .flag(cs_flag));
   m2_done_latch u_ws_latch (.CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .clear(leave),
                             .guard(entry), .done(ws_done && ws_act), .flag(ws_flag));

   always_ff @(posedge CLOCK_50_I) begin
      if (!Resetn) begin
         state       <= S_M2_IDLE;
         entry       <= 1'b0;
         fs_start    <= 1'b0;
         ct_start    <= 1'b0;
         cs_start    <= 1'b0;
         ws_start    <= 1'b0;
         m2_done     <= 1'b0;
         block_count <= '0;
      end else begin
         entry    <= 1'b0;
         fs_start <= 1'b0;
         ct_start <= 1'b0;
         cs_start <= 1'b0;
         ws_start <= 1'b0;
         m2_done  <= 1'b0;
         if (fs_rise)
            block_count <= block_count + 12'd1;
         case (state)
            S_M2_IDLE: if (m2_start) begin
               state       <= S_M2_LEAD_FS;
               entry       <= 1'b1;
               fs_start    <= 1'b1;
               block_count <= '0;
            end
            S_M2_LEAD_FS: if (leave) begin
               state    <= S_M2_LEAD_CT;
               entry    <= 1'b1;
               ct_start <= 1'b1;
            end
            S_M2_LEAD_CT: if (leave) begin
               entry    <= 1'b1;
               cs_start <= 1'b1;
               if (NUM_BLOCKS == 1) begin
                  state <= S_M2_LO_CS;
               end else begin
                  state    <= S_M2_CS_FS;
                  fs_start <= 1'b1;
               end
            end
            S_M2_CS_FS: if (leave) begin
               state    <= S_M2_CT_WS;
               entry    <= 1'b1;
               ct_start <= 1'b1;
               ws_start <= 1'b1;
            end
            // the fetch of the last block already happened in the preceding CS_FS
            S_M2_CT_WS: if (leave) begin
               entry    <= 1'b1;
               cs_start <= 1'b1;
               if (block_count == 12'(NUM_BLOCKS)) begin
                  state <= S_M2_LO_CS;
               end else begin
                  state    <= S_M2_CS_FS;
                  fs_start <= 1'b1;
               end
            end
            S_M2_LO_CS: if (leave) begin
               state    <= S_M2_LO_WS;
               entry    <= 1'b1;
               ws_start <= 1'b1;
            end
            S_M2_LO_WS: if (leave) begin
               state   <= S_M2_DONE;
               m2_done <= 1'b1;
            end
            S_M2_DONE: state <= S_M2_IDLE;
            default:   state <= S_M2_IDLE;
         endcase
      end
   end

   always_comb begin
      SRAM_address    = '0;
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
      case (state)
         S_M2_LEAD_FS, S_M2_CS_FS: SRAM_address = fs_sram_address;
         S_M2_CT_WS, S_M2_LO_WS: begin
            SRAM_address    = ws_sram_address;
            SRAM_write_data = ws_sram_write_data;
            SRAM_we_n       = ws_sram_we_n;
         end
         default: ;
      endcase
   end

`ifdef M2_SCHED_PERF_EN
   logic [31:0] perf_q;
   logic        stall;

   // one engine of the overlapped pair finished, the other still running
   assign stall = ((state == S_M2_CS_FS) && (cs_flag ^ fs_flag)) ||
                  ((state == S_M2_CT_WS) && (ct_flag ^ ws_flag));

   always_ff @(posedge CLOCK_50_I) begin
      if (!Resetn)
         perf_q <= '0;
      else if ((state == S_M2_IDLE) && m2_start)
         perf_q <= '0;
      else if (stall && (perf_q != 32'hFFFF_FFFF))
         perf_q <= perf_q + 32'd1;
   end

   assign perf_stall_cycles = perf_q;
`else
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Directed bench for m2_block_scheduler: full pass, stale done, done ordering, SRAM mux, reset, 1-block build.
module tb_m2_block_scheduler;

`ifdef M2_SCHED_PERF_EN
   localparam int PERF_STEP = 37;
`else
   localparam int PERF_STEP = 0;
`endif
   localparam int ENG_DLY = 5;

   logic CLOCK_50_I = 1'b0;
   logic Resetn     = 1'b0;

   initial forever #10 CLOCK_50_I = ~CLOCK_50_I;

   // main DUT, 2400 blocks
   logic        m2_start = 1'b0;
   logic        m2_done;
   logic        fs_start, ct_start, cs_start, ws_start;
   logic [3:0]  auto_done0 = '0;
   logic [3:0]  man_done0  = '0;
   logic [17:0] fs_sram_address    = 18'h01234;
   logic [17:0] ws_sram_address    = 18'h02222;
   logic [15:0] ws_sram_write_data = 16'h5555;
   logic        ws_sram_we_n       = 1'b0;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic [11:0] block_count;
   logic [31:0] perf_stall_cycles;
   logic [3:0]  st0;
   logic [3:0]  done0;

   assign st0   = {ws_start, cs_start, ct_start, fs_start};
   assign done0 = auto_done0 | man_done0;

   m2_block_scheduler u_dut (
      .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .m2_start(m2_start), .m2_done(m2_done),
      .fs_start(fs_start), .ct_start(ct_start), .cs_start(cs_start), .ws_start(ws_start),
      .fs_done(done0[0]), .ct_done(done0[1]), .cs_done(done0[2]), .ws_done(done0[3]),
      .fs_sram_address(fs_sram_address), .ws_sram_address(ws_sram_address),
      .ws_sram_write_data(ws_sram_write_data), .ws_sram_we_n(ws_sram_we_n),
      .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
      .block_count(block_count), .perf_stall_cycles(perf_stall_cycles)
   );

   // single-block DUT
   logic        m2_start1 = 1'b0;
   logic        m2_done1;
   logic [3:0]  st1;
   logic [3:0]  auto_done1 = '0;
   logic [17:0] sram_addr1;
   logic [15:0] sram_data1;
   logic        sram_we_n1;
   logic [11:0] block_count1;
   logic [31:0] perf1;
   logic [17:0] tie_addr = 18'h00000;
   logic [15:0] tie_data = 16'h0000;
   logic        tie_we_n = 1'b1;

   m2_block_scheduler #(.NUM_BLOCKS(1)) u_dut1 (
      .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .m2_start(m2_start1), .m2_done(m2_done1),
      .fs_start(st1[0]), .ct_start(st1[1]), .cs_start(st1[2]), .ws_start(st1[3]),
      .fs_done(auto_done1[0]), .ct_done(auto_done1[1]), .cs_done(auto_done1[2]), .ws_done(auto_done1[3]),
      .fs_sram_address(tie_addr), .ws_sram_address(tie_addr),
      .ws_sram_write_data(tie_data), .ws_sram_we_n(tie_we_n),
      .SRAM_address(sram_addr1), .SRAM_write_data(sram_data1), .SRAM_we_n(sram_we_n1),
      .block_count(block_count1), .perf_stall_cycles(perf1)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // engine models: done pulses ENG_DLY cycles after each start, start logging
   logic       auto_on0 = 1'b0;
   logic       auto_on1 = 1'b1;
   logic       log_on0  = 1'b0;
   logic [3:0] log0[$];
   logic [3:0] log1[$];
   int         st_cnt0[4] = '{default: 0};
   int         st_cnt1[4] = '{default: 0};

   initial begin
      int         cnt[8];
      logic [7:0] st_all;
      logic [7:0] d_all;
      foreach (cnt[i]) cnt[i] = 0;
      forever begin
         @(negedge CLOCK_50_I);
         st_all = {st1, st0};
         d_all  = '0;
         for (int i = 0; i < 8; i++) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) d_all[i] = 1'b1;
            end
            if (st_all[i] && ((i < 4) ? auto_on0 : auto_on1)) cnt[i] = ENG_DLY;
         end
         auto_done0 = d_all[3:0];
         auto_done1 = d_all[7:4];
         if (log_on0 && (st0 != 4'b0000)) log0.push_back(st0);
         if (st1 != 4'b0000) log1.push_back(st1);
         for (int i = 0; i < 4; i++) begin
            if (log_on0 && st0[i]) st_cnt0[i]++;
            if (st1[i]) st_cnt1[i]++;
         end
      end
   end

   // From cycle E of a state: pulse done[ia] in cycle E+ka and done[ib] in E+kb, then return the
   // negedge offset at which the next state's start st0[nxt] appears (-1 on timeout).
   task automatic run_state(input int ia, input int ka, input int ib, input int kb,
                            input int nxt, input int probe, output int cyc);
      logic [3:0] m;
      cyc = -1;
      for (int i = 1; i <= 80; i++) begin
         @(negedge CLOCK_50_I);
         if (st0[nxt]) begin
            cyc = i;
            man_done0 = '0;
            break;
         end
         m = '0;
         if (i == ka) m[ia] = 1'b1;
         if (i == kb) m[ib] = 1'b1;
         man_done0 = m;
         if (i == 20 && probe == 1) begin
            fs_sram_address = 18'h2A5A5;
            #1;
            check_val("fs_mux_addr", 32'(SRAM_address), 32'h2A5A5);
            check_val("fs_mux_we_n", 32'(SRAM_we_n), 32'd1);
         end
         if (i == 20 && probe == 2) begin
            ws_sram_address    = 18'd5;
            ws_sram_write_data = 16'hABCD;
            ws_sram_we_n       = 1'b0;
            #1;
            check_val("ws_mux_addr", 32'(SRAM_address), 32'd5);
            check_val("ws_mux_data", 32'(SRAM_write_data), 32'h0000ABCD);
            check_val("ws_mux_we_n", 32'(SRAM_we_n), 32'd0);
         end
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] p0;
      bit          got;

      // reset values
      repeat (3) @(negedge CLOCK_50_I);
      check_val("rst_starts", 32'(st0), 32'd0);
      check_val("rst_done", 32'(m2_done), 32'd0);
      check_val("rst_addr", 32'(SRAM_address), 32'd0);
      check_val("rst_data", 32'(SRAM_write_data), 32'd0);
      check_val("rst_we_n", 32'(SRAM_we_n), 32'd1);
      check_val("rst_count", 32'(block_count), 32'd0);
      check_val("rst_perf", perf_stall_cycles, 32'd0);
      Resetn = 1'b1;
      @(negedge CLOCK_50_I);

      // stale fs_done held high across LEAD_FS cycle E
      man_done0[0] = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start = 1'b0;
      check_val("lead_fs_start", 32'(st0), 32'b0001);
      check_val("lead_fs_addr", 32'(SRAM_address), 32'h01234);
      check_val("lead_fs_we_n", 32'(SRAM_we_n), 32'd1);
      @(negedge CLOCK_50_I);
      man_done0[0] = 1'b0;
      repeat (4) @(negedge CLOCK_50_I);
      check_val("stale_done_count", 32'(block_count), 32'd0);
      check_val("stale_done_no_ct", 32'(ct_start), 32'd0);
      man_done0[0] = 1'b1;
      @(negedge CLOCK_50_I);
      man_done0[0] = 1'b0;
      check_val("fresh_done_count", 32'(block_count), 32'd1);
      run_state(0, 0, 0, 0, 1, 0, cyc);
      check_val("lead_fs_exit", 32'(cyc), 32'd1);
      check_val("lead_ct_start", 32'(st0), 32'b0010);

      // LEAD_CT -> CS_FS
      run_state(1, 2, 1, 2, 2, 0, cyc);
      check_val("lead_ct_exit", 32'(cyc), 32'd4);
      check_val("cs_fs_starts", 32'(st0), 32'b0101);

      // CS_FS: cs first, fs late
      p0 = perf_stall_cycles;
      run_state(2, 3, 0, 40, 1, 1, cyc);
      check_val("cs_fs1_exit", 32'(cyc), 32'd42);
      check_val("cs_fs1_perf", perf_stall_cycles - p0, 32'(PERF_STEP));
      check_val("cs_fs1_count", 32'(block_count), 32'd2);
      check_val("ct_ws_starts", 32'(st0), 32'b1010);

      // CT_WS: ws first, ct late
      p0 = perf_stall_cycles;
      run_state(1, 40, 3, 3, 2, 2, cyc);
      check_val("ct_ws1_exit", 32'(cyc), 32'd42);
      check_val("ct_ws1_perf", perf_stall_cycles - p0, 32'(PERF_STEP));

      // CS_FS: fs first, cs late
      p0 = perf_stall_cycles;
      run_state(0, 3, 2, 40, 1, 0, cyc);
      check_val("cs_fs2_exit", 32'(cyc), 32'd42);
      check_val("cs_fs2_perf", perf_stall_cycles - p0, 32'(PERF_STEP));
      check_val("cs_fs2_count", 32'(block_count), 32'd3);

      // CT_WS: m2_start while busy, then reset mid-state
      @(negedge CLOCK_50_I);
      m2_start = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start = 1'b0;
      @(negedge CLOCK_50_I);
      check_val("busy_start_count", 32'(block_count), 32'd3);
      check_val("busy_start_pulse", 32'(st0), 32'd0);
      ws_sram_we_n = 1'b0;
      #1;
      check_val("ct_ws_we_live", 32'(SRAM_we_n), 32'd0);
      Resetn = 1'b0;
      @(negedge CLOCK_50_I);
      check_val("midrst_we_n", 32'(SRAM_we_n), 32'd1);
      check_val("midrst_addr", 32'(SRAM_address), 32'd0);
      check_val("midrst_starts", 32'(st0), 32'd0);
      check_val("midrst_count", 32'(block_count), 32'd0);
      Resetn = 1'b1;
      ws_sram_we_n = 1'b1;
      @(negedge CLOCK_50_I);

      // full pass with auto-responding engines
      auto_on0 = 1'b1;
      log_on0  = 1'b1;
      m2_start = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 45000; i++) begin
         @(negedge CLOCK_50_I);
         if (m2_done) begin
            got = 1'b1;
            break;
         end
      end
      log_on0 = 1'b0;
      check_val("full_done_seen", 32'(got), 32'd1);
      check_val("full_count", 32'(block_count), 32'd2400);
      check_val("full_fs_starts", 32'(st_cnt0[0]), 32'd2400);
      check_val("full_ct_starts", 32'(st_cnt0[1]), 32'd2400);
      check_val("full_cs_starts", 32'(st_cnt0[2]), 32'd2400);
      check_val("full_ws_starts", 32'(st_cnt0[3]), 32'd2400);
      check_val("full_perf", perf_stall_cycles, 32'd0);
      check_val("order_0", 32'(log0[0]), 32'b0001);
      check_val("order_1", 32'(log0[1]), 32'b0010);
      check_val("order_2", 32'(log0[2]), 32'b0101);
      check_val("order_3", 32'(log0[3]), 32'b1010);
      check_val("order_lo_cs", 32'(log0[log0.size() - 2]), 32'b0100);
      check_val("order_lo_ws", 32'(log0[log0.size() - 1]), 32'b1000);
      @(negedge CLOCK_50_I);
      check_val("done_one_cycle", 32'(m2_done), 32'd0);
      repeat (5) @(negedge CLOCK_50_I);
      check_val("count_holds", 32'(block_count), 32'd2400);
      m2_start = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start = 1'b0;
      check_val("count_clears", 32'(block_count), 32'd0);
      auto_on0 = 1'b0;
      Resetn   = 1'b0;
      repeat (2) @(negedge CLOCK_50_I);
      Resetn = 1'b1;
      repeat (8) @(negedge CLOCK_50_I);

      // single-block build
      m2_start1 = 1'b1;
      @(negedge CLOCK_50_I);
      m2_start1 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLOCK_50_I);
         if (m2_done1) begin
            got = 1'b1;
            break;
         end
      end
      repeat (5) @(negedge CLOCK_50_I);
      check_val("one_done_seen", 32'(got), 32'd1);
      check_val("one_count", 32'(block_count1), 32'd1);
      check_val("one_log_size", 32'(log1.size()), 32'd4);
      check_val("one_order_0", 32'(log1[0]), 32'b0001);
      check_val("one_order_1", 32'(log1[1]), 32'b0010);
      check_val("one_order_2", 32'(log1[2]), 32'b0100);
      check_val("one_order_3", 32'(log1[3]), 32'b1000);
      for (int i = 0; i < 4; i++)
         check_val($sformatf("one_starts_%0d", i), 32'(st_cnt1[i]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
